// File: rtl/ext_mem_cache_ctrl.sv
// ext_mem_cache_ctrl: write-through, fully associative cache in front of the SPI memory engine,
// with runtime bypass, flush and saturating hit/miss statistics.
module ext_mem_cache_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_ENTRIES = 16,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              cache_en,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int IW = $clog2(NUM_ENTRIES);
  localparam int TW = ADDR_W - 2;
  typedef enum logic [2:0] {IDLE, FLUSH, LOOKUP, MEM_REQ, MEM_WAIT, RESP} state_t;
  state_t state;
  logic flush_pending, fill, hit, inv;
  logic [NUM_ENTRIES-1:0] valid;
  logic [TW-1:0] tags [NUM_ENTRIES];
  logic [DATA_W-1:0] data [NUM_ENTRIES];
  logic [IW-1:0] ptr, hidx, iidx, fidx;
  assign req_ready = !reset && state == IDLE && !flush_pending;
  assign busy = state != IDLE || flush_pending;
  assign fidx = inv ? iidx : ptr;
  // Descending scan so the lowest matching / lowest invalid index wins.
  always_comb begin
    hit = 1'b0;
    hidx = '0;
    inv = 1'b0;
    iidx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && tags[i] == mem_req_addr[ADDR_W-1:2]) begin
        hit = 1'b1;
        hidx = IW'(i);
      end
      if (!valid[i]) begin
        inv = 1'b1;
        iidx = IW'(i);
      end
    end
  end
  // The mem_req payload registers double as the captured request.
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      state <= IDLE;
      flush_pending <= 1'b0;
      fill <= 1'b0;
      valid <= '0;
      tags <= '{default: '0};
      data <= '{default: '0};
      ptr <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we <= 1'b0;
      mem_req_addr <= '0;
      mem_req_wdata <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (flush) flush_pending <= 1'b1;
      case (state)
        IDLE:
          if (flush_pending) state <= FLUSH;
          else if (req_valid) begin
            mem_req_we <= req_we;
            mem_req_addr <= req_addr;
            mem_req_wdata <= req_wdata;
            state <= LOOKUP;
          end
        FLUSH: begin
          valid <= '0;
          ptr <= '0;
          flush_pending <= flush;
          state <= IDLE;
        end
        LOOKUP: begin
          fill <= cache_en && !mem_req_we;
          if (cache_en && !mem_req_we && hit) begin
            rsp_rdata <= data[hidx];
            if (!(&hit_count)) hit_count <= hit_count + 1'b1;
            state <= RESP;
          end else begin
            if (cache_en && !mem_req_we && !(&miss_count)) miss_count <= miss_count + 1'b1;
            if (cache_en && mem_req_we && hit) data[hidx] <= mem_req_wdata;
            mem_req_valid <= 1'b1;
            state <= MEM_REQ;
          end
        end
        MEM_REQ:
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state <= MEM_WAIT;
          end
        MEM_WAIT:
          if (mem_rsp_valid) begin
            if (!mem_req_we) rsp_rdata <= mem_rsp_rdata;
            if (fill) begin
              valid[fidx] <= 1'b1;
              tags[fidx] <= mem_req_addr[ADDR_W-1:2];
              data[fidx] <= mem_rsp_rdata;
              if (!inv) ptr <= ptr + 1'b1;
            end
            state <= RESP;
          end
        RESP: begin
          rsp_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ext_mem_cache_ctrl.sv
// tb_ext_mem_cache_ctrl: directed checks of hit/miss, write-update, replacement, flush, bypass and reset abort.
module tb_ext_mem_cache_ctrl;
  logic CLK = 1'b0, reset = 1'b1, cache_en = 1'b1, flush = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rsp_rdata = '0;
  logic req_ready, rsp_valid, mem_req_valid, mem_req_we, busy;
  logic [31:0] rsp_rdata, mem_req_addr, mem_req_wdata;
  logic [15:0] hit_count, miss_count;
  int tests = 0, fails = 0;
  int t_nmem, t_cyc, t_nrsp, acc;
  logic t_mwe, t_stable, t_done;
  logic [31:0] t_maddr, t_mwdata, t_rdata;

  ext_mem_cache_ctrl #(.ADDR_W(32), .DATA_W(32), .NUM_ENTRIES(16), .CNT_W(16)) dut (
    .CLK(CLK), .reset(reset), .cache_en(cache_en), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata), .busy(busy), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issues one request and acts as the backend: ready after rdy stalled cycles, response lat cycles later.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] rd, input int lat, input int rdy, input int fl_at);
    int k, held, wcnt;
    logic [31:0] pa, pw;
    logic pwe;
    k = 0;
    while (!req_ready && k < 50) begin
      step();
      k++;
    end
    req_valid = 1'b1;
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
    t_nmem = 0; t_nrsp = 0; t_cyc = -1; t_done = 1'b0; t_stable = 1'b1;
    held = 0; wcnt = 0; pa = '0; pw = '0; pwe = 1'b0;
    for (int c = 0; c < 60 && !t_done; c++) begin
      flush = (c == fl_at);
      if (rsp_valid) begin
        t_nrsp++;
        t_cyc = c;
        t_rdata = rsp_rdata;
        t_done = 1'b1;
      end
      mem_rsp_valid = 1'b0;
      if (wcnt > 0) begin
        wcnt--;
        if (wcnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = rd;
        end
      end
      if (mem_req_valid) begin
        if (held == 0) begin
          pa = mem_req_addr; pw = mem_req_wdata; pwe = mem_req_we;
        end else if (mem_req_addr !== pa || mem_req_wdata !== pw || mem_req_we !== pwe) t_stable = 1'b0;
        if (held >= rdy) begin
          mem_req_ready = 1'b1;
          t_nmem++;
          t_mwe = mem_req_we; t_maddr = mem_req_addr; t_mwdata = mem_req_wdata;
          wcnt = lat;
        end
        held++;
      end else mem_req_ready = 1'b0;
      step();
    end
    flush = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    if (rsp_valid) t_nrsp++;
    chk("txn_done", t_done, 1);
  endtask

  initial begin
    repeat (3) step();
    chk("rst_ready_low", req_ready, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step();
    chk("idle_ready", req_ready, 1);
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_rdata", rsp_rdata, 0);
    chk("idle_mreq", mem_req_valid, 0);
    chk("idle_hits", hit_count, 0);
    chk("idle_misses", miss_count, 0);
    // Cold read miss
    txn(1'b0, 32'h100, 0, 32'hDEADBEEF, 3, 0, -1);
    chk("miss_rdata", t_rdata, 32'hDEADBEEF);
    chk("miss_nrsp", t_nrsp, 1);
    chk("miss_nmem", t_nmem, 1);
    chk("miss_maddr", t_maddr, 32'h100);
    chk("miss_mwe", t_mwe, 0);
    chk("miss_count1", miss_count, 1);
    // Hits, including another byte of the same word
    txn(1'b0, 32'h100, 0, 32'h0, 3, 0, -1);
    chk("hit_rdata", t_rdata, 32'hDEADBEEF);
    chk("hit_latency", t_cyc, 2);
    chk("hit_nmem", t_nmem, 0);
    txn(1'b0, 32'h102, 0, 32'h0, 3, 0, -1);
    chk("hit2_rdata", t_rdata, 32'hDEADBEEF);
    chk("hit2_nmem", t_nmem, 0);
    chk("hit_count2", hit_count, 2);
    chk("miss_count_h", miss_count, 1);
    // Write-through with write-update, then non-allocating write miss
    txn(1'b1, 32'h100, 32'h12345678, 32'h0, 2, 0, -1);
    chk("wr_nmem", t_nmem, 1);
    chk("wr_mwe", t_mwe, 1);
    chk("wr_mwdata", t_mwdata, 32'h12345678);
    chk("wr_rdata_held", t_rdata, 32'hDEADBEEF);
    txn(1'b0, 32'h100, 0, 32'h0, 2, 0, -1);
    chk("wu_rdata", t_rdata, 32'h12345678);
    chk("wu_nmem", t_nmem, 0);
    chk("hit_count3", hit_count, 3);
    txn(1'b1, 32'h200, 32'hAAAA5555, 32'h0, 2, 0, -1);
    chk("wmiss_nmem", t_nmem, 1);
    txn(1'b0, 32'h200, 0, 32'hCAFE0200, 2, 0, -1);
    chk("wmiss_read_nmem", t_nmem, 1);
    chk("wmiss_read_rdata", t_rdata, 32'hCAFE0200);
    chk("miss_count2", miss_count, 2);
    // Flush from idle, then fill all entries and one more
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", busy, 1);
    chk("flush_not_ready", req_ready, 0);
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      txn(1'b0, 32'(i * 4), 0, 32'hA0000000 | 32'(i * 4), 1, 0, -1);
      acc += t_nmem;
    end
    chk("fill17_nmem", acc, 17);
    chk("miss_count19", miss_count, 19);
    txn(1'b0, 32'h4, 0, 32'h0, 1, 0, -1);
    chk("rr_keep4_nmem", t_nmem, 0);
    chk("rr_keep4_rdata", t_rdata, 32'hA0000004);
    txn(1'b0, 32'h0, 0, 32'hB0000000, 1, 0, -1);
    chk("rr_evict0_nmem", t_nmem, 1);
    txn(1'b0, 32'h40, 0, 32'h0, 1, 0, -1);
    chk("rr_new40_rdata", t_rdata, 32'hA0000040);
    chk("rr_new40_nmem", t_nmem, 0);
    chk("hit_count5", hit_count, 5);
    chk("miss_count20", miss_count, 20);
    // Flush while MEM_WAIT is outstanding, with a 5-cycle backend stall
    txn(1'b0, 32'h300, 0, 32'h33330300, 3, 5, 8);
    chk("fl_rdata", t_rdata, 32'h33330300);
    chk("fl_nrsp", t_nrsp, 1);
    chk("fl_nmem", t_nmem, 1);
    chk("stall_stable", t_stable, 1);
    chk("stall_maddr", t_maddr, 32'h300);
    txn(1'b0, 32'h300, 0, 32'h33330301, 1, 0, -1);
    chk("fl_remiss_nmem", t_nmem, 1);
    txn(1'b0, 32'h40, 0, 32'h40400040, 1, 0, -1);
    chk("fl_remiss40_nmem", t_nmem, 1);
    chk("miss_count23", miss_count, 23);
    // Bypass leaves cache and counters untouched
    cache_en = 1'b0;
    txn(1'b0, 32'h40, 0, 32'h11110040, 1, 0, -1);
    chk("byp1_nmem", t_nmem, 1);
    chk("byp1_rdata", t_rdata, 32'h11110040);
    txn(1'b0, 32'h40, 0, 32'h22220040, 1, 0, -1);
    chk("byp2_nmem", t_nmem, 1);
    chk("byp2_rdata", t_rdata, 32'h22220040);
    chk("byp_hits", hit_count, 5);
    chk("byp_misses", miss_count, 23);
    cache_en = 1'b1;
    txn(1'b0, 32'h40, 0, 32'h0, 1, 0, -1);
    chk("byp_after_hit_rdata", t_rdata, 32'h40400040);
    chk("hit_count6", hit_count, 6);
    // Reset during MEM_WAIT aborts; a late backend response is ignored
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h500;
    step();
    req_valid = 1'b0;
    step();
    chk("abort_mreq", mem_req_valid, 1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("abort_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("abort_busy0", busy, 0);
    chk("abort_ready0", req_ready, 0);
    chk("abort_maddr0", mem_req_addr, 0);
    chk("abort_mreq0", mem_req_valid, 0);
    chk("abort_rdata0", rsp_rdata, 0);
    chk("abort_hits0", hit_count, 0);
    chk("abort_misses0", miss_count, 0);
    step();
    reset = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'h0BAD0BAD;
    step();
    mem_rsp_valid = 1'b0;
    acc = 0;
    repeat (5) begin
      if (rsp_valid) acc++;
      step();
    end
    chk("abort_no_rsp", acc, 0);
    chk("abort_rdata_after", rsp_rdata, 0);
    chk("abort_ready_after", req_ready, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
